// File: rtl/codec_biterr_frame_acc.sv
// Purpose : accumulates per-word bit-error counts into per-frame totals and running statistics.
// Latency : frame result (oval/oerr/obad) and statistics appear one enabled cycle after the eop word.
// Backpr. : none; accepts one word per enabled clock, iclkena=0 freezes all state and outputs.
//
// Ports:
//   iclk, ireset_n        clock, asynchronous active-low reset
//   iclkena               clock enable; everything holds while low
//   ival/isop/ieop/ierr   word valid, frame delimiters and per-word error count
//   iclear                synchronous clear of statistics and any open frame (highest priority)
//   oval/oerr/obad        frame-done pulse, frame error total, frame-had-errors flag
//   oabort                pulse when an open frame is discarded by a new isop
//   ofrm_num/obit_num/obad_num  saturating frame, bit-error and bad-frame counters
module codec_biterr_frame_acc #(
    parameter int pERR_W  = 16,
    parameter int pFERR_W = 24,
    parameter int pCNT_W  = 32
) (
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               iclkena,
    input  logic               ival,
    input  logic               isop,
    input  logic               ieop,
    input  logic [pERR_W-1:0]  ierr,
    input  logic               iclear,
    output logic               oval,
    output logic [pFERR_W-1:0] oerr,
    output logic               obad,
    output logic               oabort,
    output logic [pCNT_W-1:0]  ofrm_num,
    output logic [pCNT_W-1:0]  obit_num,
    output logic [pCNT_W-1:0]  obad_num
);

    // One extra bit above the wider operand so saturation can be detected.
    localparam int AW = ((pFERR_W > pERR_W) ? pFERR_W : pERR_W) + 1;
    localparam int BW = ((pCNT_W > pFERR_W) ? pCNT_W : pFERR_W) + 1;
    localparam logic [AW-1:0] FMAX = (AW'(1) << pFERR_W) - AW'(1);
    localparam logic [BW-1:0] CMAX = (BW'(1) << pCNT_W) - BW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t              state;
    logic [pFERR_W-1:0]  acc;

    logic [pFERR_W-1:0]  acc_base;
    logic [AW-1:0]       sum_ext;
    logic [pFERR_W-1:0]  fin;
    logic [BW-1:0]       bit_ext;
    logic [pCNT_W-1:0]   bit_next;
    logic [pCNT_W-1:0]   frm_next;
    logic [pCNT_W-1:0]   bad_next;
    logic                frame_word;

    always_comb begin
        // Any isop restarts from zero, so the old sum only carries into a continuing word.
        acc_base   = ((state == FRAME) && !isop) ? acc : '0;
        sum_ext    = AW'(acc_base) + AW'(ierr);
        fin        = (sum_ext > FMAX) ? '1 : sum_ext[pFERR_W-1:0];
        // Words outside a frame (IDLE without isop) are dropped.
        frame_word = isop || (state == FRAME);

        bit_ext    = BW'(obit_num) + BW'(fin);
        bit_next   = (bit_ext > CMAX) ? '1 : bit_ext[pCNT_W-1:0];
        frm_next   = (ofrm_num == '1) ? ofrm_num : ofrm_num + pCNT_W'(1);
        bad_next   = ((obad_num == '1) || (fin == '0)) ? obad_num : obad_num + pCNT_W'(1);
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state    <= IDLE;
            acc      <= '0;
            oval     <= 1'b0;
            oabort   <= 1'b0;
            oerr     <= '0;
            obad     <= 1'b0;
            ofrm_num <= '0;
            obit_num <= '0;
            obad_num <= '0;
        end else if (iclkena) begin
            oval   <= 1'b0;
            oabort <= 1'b0;
            if (iclear) begin
                // Clear wins over any word presented on the same edge.
                state    <= IDLE;
                acc      <= '0;
                ofrm_num <= '0;
                obit_num <= '0;
                obad_num <= '0;
            end else if (ival && frame_word) begin
                if (isop && (state == FRAME)) begin
                    oabort <= 1'b1;
                end
                if (ieop) begin
                    state    <= IDLE;
                    acc      <= '0;
                    oval     <= 1'b1;
                    oerr     <= fin;
                    obad     <= (fin != '0);
                    ofrm_num <= frm_next;
                    obit_num <= bit_next;
                    obad_num <= bad_next;
                end else begin
                    state <= FRAME;
                    acc   <= fin;
                end
            end
        end
    end

endmodule
